// File: rtl/sonar_sequenciador.sv
// sonar_sequenciador: servo sweep sequencer for the sonar.
// Steps the servo through positions 0..7 and back (ping-pong). At each position it
// waits for the servo to settle, triggers a measurement, sends the result over
// serial, then moves on.
// Optional feature: define SONAR_SEQUENCIADOR_TIMEOUT_EN to abandon a measurement
// that does not answer within T_TIMEOUT cycles. Without it the block waits forever.
module sonar_sequenciador #(
  parameter int unsigned T_POSICAO = 25_000_000,
  parameter int unsigned T_TIMEOUT = 3_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       pronto_medida,
  input  logic       fim_transmissao,
  output logic       medir,
  output logic       partida_tx,
  output logic [2:0] posicao,
  output logic       fim_posicao,
  output logic       timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [2:0] {
    INICIAL        = 3'd0,
    PREPARA        = 3'd1,
    ESPERA_POSICAO = 3'd2,
    MEDE           = 3'd3,
    AGUARDA_MEDIDA = 3'd4,
    TRANSMITE      = 3'd5,
    AGUARDA_TX     = 3'd6,
    PROXIMA        = 3'd7
  } estado_t;

  localparam logic [31:0] LIMITE_POSICAO = 32'(T_POSICAO - 1);
  localparam logic [31:0] LIMITE_TIMEOUT = 32'(T_TIMEOUT - 1);

  estado_t     estado;
  logic        descendo;
  logic [31:0] timer;
  logic        inverte;

  // The sweep reverses when it sits at the end of travel in its current direction
  assign inverte = descendo ? (posicao == 3'd0) : (posicao == 3'd7);

  // Debug display shows the raw state encoding
  assign db_estado = {1'b0, estado};

  // Sequencer: state, timer, sweep position and registered one-cycle pulses
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado      <= INICIAL;
      posicao     <= 3'd0;
      descendo    <= 1'b0;
      timer       <= 32'd0;
      medir       <= 1'b0;
      partida_tx  <= 1'b0;
      fim_posicao <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      medir       <= 1'b0;
      partida_tx  <= 1'b0;
      fim_posicao <= 1'b0;
      timeout     <= 1'b0;
      case (estado)
        INICIAL: begin
          if (ligar) estado <= PREPARA;
        end
        PREPARA: begin
          posicao  <= 3'd0;
          descendo <= 1'b0;
          timer    <= 32'd0;
          estado   <= ESPERA_POSICAO;
        end
        ESPERA_POSICAO: begin
          if (timer == LIMITE_POSICAO) begin
            timer  <= 32'd0;
            medir  <= 1'b1;
            estado <= MEDE;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        MEDE: begin
          estado <= AGUARDA_MEDIDA;
        end
        AGUARDA_MEDIDA: begin
          if (pronto_medida) begin
            timer      <= 32'd0;
            partida_tx <= 1'b1;
            estado     <= TRANSMITE;
          end
`ifdef SONAR_SEQUENCIADOR_TIMEOUT_EN
          else if (timer == LIMITE_TIMEOUT) begin
            timer       <= 32'd0;
            timeout     <= 1'b1;
            fim_posicao <= inverte;
            estado      <= PROXIMA;
          end else begin
            timer <= timer + 32'd1;
          end
`else
          else if (timer != LIMITE_TIMEOUT) begin
            // Waiting is unbounded here; the counter just saturates instead of wrapping
            timer <= timer + 32'd1;
          end
`endif
        end
        TRANSMITE: begin
          estado <= AGUARDA_TX;
        end
        AGUARDA_TX: begin
          if (fim_transmissao) begin
            fim_posicao <= inverte;
            estado      <= PROXIMA;
          end
        end
        PROXIMA: begin
          if (inverte) begin
            descendo <= ~descendo;
            posicao  <= descendo ? 3'd1 : 3'd6;
          end else begin
            posicao <= descendo ? (posicao - 3'd1) : (posicao + 3'd1);
          end
          timer  <= 32'd0;
          estado <= ligar ? ESPERA_POSICAO : INICIAL;
        end
        default: estado <= INICIAL;
      endcase
    end
  end

endmodule

// File: tb/tb_sonar_sequenciador.sv
// tb_sonar_sequenciador: randomized self-checking bench for sonar_sequenciador.
// A responder answers medir/partida_tx after chosen delays; a monitor logs every
// cycle's state, position and pulses; each test compares the log to timings
// computed from the sequencing rules.
module tb_sonar_sequenciador;

  localparam int T_POS = 10;
  localparam int T_TO  = 20;

  logic       clock = 1'b0;
  logic       reset;
  logic       ligar;
  logic       pronto_medida = 1'b0;
  logic       fim_transmissao = 1'b0;
  logic       medir, partida_tx, fim_posicao, timeout;
  logic [2:0] posicao;
  logic [3:0] db_estado;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int medir_q[$], tx_q[$], timeout_q[$], fimpos_q[$], pronto_q[$], fim_q[$];
  int stray_pq[$], stray_fq[$];
  logic [2:0] pos_hist[int];
  logic [3:0] st_hist[int];

  int k_pronto_cfg = 0;
  int k_fim_cfg = 0;
  int tgt_pronto = -1;
  int tgt_fim = -1;

  sonar_sequenciador #(.T_POSICAO(T_POS), .T_TIMEOUT(T_TO)) dut (
    .clock(clock), .reset(reset), .ligar(ligar),
    .pronto_medida(pronto_medida), .fim_transmissao(fim_transmissao),
    .medir(medir), .partida_tx(partida_tx), .posicao(posicao),
    .fim_posicao(fim_posicao), .timeout(timeout), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  function automatic bit is_in(input int q[$], input int v);
    foreach (q[i]) if (q[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int at(input int q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return -1;
  endfunction

  // Expected servo position at measurement n of an uninterrupted sweep
  function automatic int pos_at(input int n);
    int p;
    p = n % 14;
    return (p <= 7) ? p : 14 - p;
  endfunction

  // Monitor: one log entry per clock, taken just after the edge
  always @(posedge clock) begin
    #1;
    cyc++;
    pos_hist[cyc] = posicao;
    st_hist[cyc]  = db_estado;
    if (medir)       medir_q.push_back(cyc);
    if (partida_tx)  tx_q.push_back(cyc);
    if (timeout)     timeout_q.push_back(cyc);
    if (fim_posicao) fimpos_q.push_back(cyc);
  end

  // Responder: answers measurement and transmission after configured delays
  always @(negedge clock) begin
    int k;
    pronto_medida   = (cyc == tgt_pronto) || is_in(stray_pq, cyc);
    fim_transmissao = (cyc == tgt_fim) || is_in(stray_fq, cyc);
    if (pronto_medida)   pronto_q.push_back(cyc);
    if (fim_transmissao) fim_q.push_back(cyc);
    if (medir) begin
      k = (k_pronto_cfg < 0) ? int'($urandom_range(8, 1)) : k_pronto_cfg;
      tgt_pronto = (k == 0) ? -1 : cyc + k;
    end
    if (partida_tx) begin
      k = (k_fim_cfg < 0) ? int'($urandom_range(10, 1)) : k_fim_cfg;
      tgt_fim = (k == 0) ? -1 : cyc + k;
    end
  end

  task automatic clear_logs();
    medir_q.delete(); tx_q.delete(); timeout_q.delete(); fimpos_q.delete();
    pronto_q.delete(); fim_q.delete(); stray_pq.delete(); stray_fq.delete();
    tgt_pronto = -1; tgt_fim = -1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic wait_medir(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (medir_q.size() >= n) ok = 1'b1;
      else @(negedge clock);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0; ligar = 1'b0; k_pronto_cfg = 0; k_fim_cfg = 0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    clear_logs();
  endtask

  task automatic test_reset();
    int l, bad;
    reset = 1'b0; ligar = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (db_estado !== 4'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d want 0", db_estado); end
    checks++; if (posicao !== 3'd0) begin errors++; $display("[TB] FAIL reset_pos: got %0d want 0", posicao); end
    checks++; if ({medir, partida_tx, fim_posicao, timeout} !== 4'b0) begin errors++; $display("[TB] FAIL reset_pulses: got %b want 0000", {medir, partida_tx, fim_posicao, timeout}); end
    reset = 1'b1; clear_logs(); l = cyc;
    wait_until(l + 100);
    bad = 0;
    for (int c = l + 1; c <= l + 100; c++) if (st_hist[c] !== 4'd0 || pos_hist[c] !== 3'd0) bad++;
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL idle_state: got %0d off cycles want 0", bad); end
    checks++; if (medir_q.size() + tx_q.size() + timeout_q.size() + fimpos_q.size() !== 0) begin errors++; $display("[TB] FAIL idle_pulses: got %0d want 0", medir_q.size() + tx_q.size() + timeout_q.size() + fimpos_q.size()); end
  endtask

  task automatic test_first_measure();
    int l, e_m, e_tx, e_prox;
    bit ok;
    do_reset(); k_pronto_cfg = 5; k_fim_cfg = 8;
    ligar = 1'b1; l = cyc;
    e_m = l + 2 + T_POS; e_tx = e_m + 6; e_prox = e_tx + 9;
    wait_medir(2, 200, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL first_wait: got %0d medir want 2", medir_q.size()); end
    checks++; if (at(medir_q, 0) !== e_m) begin errors++; $display("[TB] FAIL first_medir: got %0d want %0d", at(medir_q, 0), e_m); end
    checks++; if (at(tx_q, 0) !== e_tx) begin errors++; $display("[TB] FAIL first_tx: got %0d want %0d", at(tx_q, 0), e_tx); end
    checks++; if (st_hist[e_prox] !== 4'd7 || pos_hist[e_prox] !== 3'd0) begin errors++; $display("[TB] FAIL first_proxima: got st=%0d pos=%0d want st=7 pos=0", st_hist[e_prox], pos_hist[e_prox]); end
    checks++; if (pos_hist[e_prox + 1] !== 3'd1) begin errors++; $display("[TB] FAIL first_advance: got %0d want 1", pos_hist[e_prox + 1]); end
    checks++; if (at(medir_q, 1) !== e_prox + 1 + T_POS) begin errors++; $display("[TB] FAIL second_medir: got %0d want %0d", at(medir_q, 1), e_prox + 1 + T_POS); end
    checks++; if (timeout_q.size() + fimpos_q.size() !== 0) begin errors++; $display("[TB] FAIL first_extra: got %0d want 0", timeout_q.size() + fimpos_q.size()); end
  endtask

  task automatic test_sweep();
    bit ok;
    do_reset(); k_pronto_cfg = -1; k_fim_cfg = -1;
    ligar = 1'b1;
    wait_medir(16, 3000, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL sweep_wait: got %0d medir want 16", medir_q.size()); end
    for (int n = 0; n < 16; n++) begin
      checks++; if (pos_hist[at(medir_q, n)] !== 3'(pos_at(n))) begin errors++; $display("[TB] FAIL sweep_pos[%0d]: got %0d want %0d", n, pos_hist[at(medir_q, n)], pos_at(n)); end
    end
    for (int n = 0; n < 15; n++) begin
      checks++; if (at(tx_q, n) !== at(pronto_q, n) + 1) begin errors++; $display("[TB] FAIL sweep_tx[%0d]: got %0d want %0d", n, at(tx_q, n), at(pronto_q, n) + 1); end
      checks++; if (at(medir_q, n + 1) !== at(fim_q, n) + 2 + T_POS) begin errors++; $display("[TB] FAIL sweep_settle[%0d]: got %0d want %0d", n, at(medir_q, n + 1), at(fim_q, n) + 2 + T_POS); end
    end
    checks++; if (fimpos_q.size() !== 2) begin errors++; $display("[TB] FAIL sweep_fimpos_count: got %0d want 2", fimpos_q.size()); end
    checks++; if (at(fimpos_q, 0) !== at(fim_q, 7) + 1 || pos_hist[at(fimpos_q, 0)] !== 3'd7) begin errors++; $display("[TB] FAIL sweep_rev_top: got %0d want %0d", at(fimpos_q, 0), at(fim_q, 7) + 1); end
    checks++; if (at(fimpos_q, 1) !== at(fim_q, 14) + 1 || pos_hist[at(fimpos_q, 1)] !== 3'd0) begin errors++; $display("[TB] FAIL sweep_rev_bottom: got %0d want %0d", at(fimpos_q, 1), at(fim_q, 14) + 1); end
  endtask

  task automatic test_timeout();
    int l, e_m, bad;
`ifdef SONAR_SEQUENCIADOR_TIMEOUT_EN
    int e_to;
`endif
    do_reset(); k_pronto_cfg = 0; k_fim_cfg = 3;
    ligar = 1'b1; l = cyc; e_m = l + 2 + T_POS;
`ifdef SONAR_SEQUENCIADOR_TIMEOUT_EN
    e_to = e_m + 1 + T_TO;
    wait_until(e_to + T_POS + 3);
    checks++; if (at(timeout_q, 0) !== e_to || timeout_q.size() !== 1) begin errors++; $display("[TB] FAIL timeout_pulse: got %0d (n=%0d) want %0d", at(timeout_q, 0), timeout_q.size(), e_to); end
    checks++; if (st_hist[e_to] !== 4'd7) begin errors++; $display("[TB] FAIL timeout_state: got %0d want 7", st_hist[e_to]); end
    checks++; if (pos_hist[e_to + 1] !== 3'd1) begin errors++; $display("[TB] FAIL timeout_advance: got %0d want 1", pos_hist[e_to + 1]); end
    checks++; if (tx_q.size() !== 0) begin errors++; $display("[TB] FAIL timeout_no_tx: got %0d want 0", tx_q.size()); end
    checks++; if (at(medir_q, 1) !== e_to + 1 + T_POS) begin errors++; $display("[TB] FAIL timeout_next_medir: got %0d want %0d", at(medir_q, 1), e_to + 1 + T_POS); end
`else
    wait_until(e_m + 1001);
    bad = 0;
    for (int c = e_m + 1; c <= e_m + 1000; c++) if (st_hist[c] !== 4'd4) bad++;
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL wait_forever: got %0d cycles off state 4 want 0", bad); end
    checks++; if (timeout_q.size() + tx_q.size() !== 0) begin errors++; $display("[TB] FAIL wait_forever_pulses: got %0d want 0", timeout_q.size() + tx_q.size()); end
    checks++; if (medir_q.size() !== 1) begin errors++; $display("[TB] FAIL wait_forever_medir: got %0d want 1", medir_q.size()); end
`endif
  endtask

  task automatic test_boundary();
    int l, e_m;
    do_reset(); k_pronto_cfg = T_TO; k_fim_cfg = 2;
    ligar = 1'b1; l = cyc; e_m = l + 2 + T_POS;
    wait_until(e_m + T_TO + 6);
    checks++; if (at(tx_q, 0) !== e_m + T_TO + 1) begin errors++; $display("[TB] FAIL edge_tx: got %0d want %0d", at(tx_q, 0), e_m + T_TO + 1); end
    checks++; if (timeout_q.size() !== 0) begin errors++; $display("[TB] FAIL edge_no_timeout: got %0d want 0", timeout_q.size()); end
`ifdef SONAR_SEQUENCIADOR_TIMEOUT_EN
    do_reset(); k_pronto_cfg = T_TO + 1; k_fim_cfg = 2;
    ligar = 1'b1; l = cyc; e_m = l + 2 + T_POS;
    wait_until(e_m + T_TO + 8);
    checks++; if (at(timeout_q, 0) !== e_m + T_TO + 1) begin errors++; $display("[TB] FAIL late_timeout: got %0d want %0d", at(timeout_q, 0), e_m + T_TO + 1); end
    checks++; if (tx_q.size() !== 0) begin errors++; $display("[TB] FAIL late_no_tx: got %0d want 0", tx_q.size()); end
`endif
  endtask

  task automatic test_ligar_drop();
    int l, e_m, e_tx, e_prox;
    do_reset(); k_pronto_cfg = 3; k_fim_cfg = 6;
    ligar = 1'b1; l = cyc;
    e_m = l + 2 + T_POS; e_tx = e_m + 4; e_prox = e_tx + 7;
    wait_until(e_tx + 2);
    ligar = 1'b0;
    wait_until(e_prox + 30);
    checks++; if (at(tx_q, 0) !== e_tx) begin errors++; $display("[TB] FAIL drop_tx: got %0d want %0d", at(tx_q, 0), e_tx); end
    checks++; if (st_hist[e_prox] !== 4'd7 || st_hist[e_prox + 1] !== 4'd0) begin errors++; $display("[TB] FAIL drop_stop: got %0d,%0d want 7,0", st_hist[e_prox], st_hist[e_prox + 1]); end
    checks++; if (pos_hist[e_prox + 1] !== 3'd1) begin errors++; $display("[TB] FAIL drop_pos_held: got %0d want 1", pos_hist[e_prox + 1]); end
    checks++; if (medir_q.size() !== 1 || st_hist[e_prox + 30] !== 4'd0) begin errors++; $display("[TB] FAIL drop_idle: got medir=%0d st=%0d want 1,0", medir_q.size(), st_hist[e_prox + 30]); end
    do_reset(); k_pronto_cfg = 2; k_fim_cfg = 3;
    ligar = 1'b1; l = cyc;
    e_m = l + 2 + T_POS; e_tx = e_m + 3; e_prox = e_tx + 4;
    wait_until(l + 5);
    ligar = 1'b0;
    wait_until(e_prox + 20);
    checks++; if (at(medir_q, 0) !== e_m || at(tx_q, 0) !== e_tx) begin errors++; $display("[TB] FAIL drop_early_cycle: got %0d,%0d want %0d,%0d", at(medir_q, 0), at(tx_q, 0), e_m, e_tx); end
    checks++; if (st_hist[e_prox + 1] !== 4'd0 || medir_q.size() !== 1) begin errors++; $display("[TB] FAIL drop_early_stop: got st=%0d medir=%0d want 0,1", st_hist[e_prox + 1], medir_q.size()); end
  endtask

  task automatic test_reset_mid();
    int l, e_prox;
    bit ok;
    do_reset(); k_pronto_cfg = 2; k_fim_cfg = 2;
    ligar = 1'b1; l = cyc;
    e_prox = l + 2 + T_POS + 3 + 3;
    wait_until(e_prox + 5);
    checks++; if (st_hist[e_prox + 5] !== 4'd2 || pos_hist[e_prox + 5] !== 3'd1) begin errors++; $display("[TB] FAIL mid_pre: got st=%0d pos=%0d want 2,1", st_hist[e_prox + 5], pos_hist[e_prox + 5]); end
    #2 reset = 1'b0;
    #1;
    checks++; if (db_estado !== 4'd0 || posicao !== 3'd0) begin errors++; $display("[TB] FAIL mid_async: got st=%0d pos=%0d want 0,0", db_estado, posicao); end
    ligar = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1; clear_logs(); l = cyc;
    wait_until(l + 30);
    checks++; if (medir_q.size() + tx_q.size() !== 0 || st_hist[l + 30] !== 4'd0) begin errors++; $display("[TB] FAIL mid_idle: got pulses=%0d st=%0d want 0,0", medir_q.size() + tx_q.size(), st_hist[l + 30]); end
    ligar = 1'b1; l = cyc;
    wait_medir(1, 100, ok);
    checks++; if (at(medir_q, 0) !== l + 2 + T_POS || pos_hist[l + 2 + T_POS] !== 3'd0) begin errors++; $display("[TB] FAIL mid_restart: got %0d want %0d", at(medir_q, 0), l + 2 + T_POS); end
  endtask

  task automatic test_ignored();
    int l, e_m, e_tx;
    do_reset(); k_pronto_cfg = 6; k_fim_cfg = 5;
    l = cyc; e_m = l + 1 + 2 + T_POS; e_tx = e_m + 7;
    stray_pq.push_back(l + 5); stray_fq.push_back(l + 7);
    stray_fq.push_back(e_m + 2); stray_pq.push_back(e_tx + 2);
    @(negedge clock);
    ligar = 1'b1;
    wait_until(e_tx + 10);
    checks++; if (at(medir_q, 0) !== e_m) begin errors++; $display("[TB] FAIL stray_medir: got %0d want %0d", at(medir_q, 0), e_m); end
    checks++; if (at(tx_q, 0) !== e_tx || tx_q.size() !== 1) begin errors++; $display("[TB] FAIL stray_tx: got %0d (n=%0d) want %0d", at(tx_q, 0), tx_q.size(), e_tx); end
    checks++; if (st_hist[e_m + 3] !== 4'd4) begin errors++; $display("[TB] FAIL stray_wait_medida: got %0d want 4", st_hist[e_m + 3]); end
    checks++; if (st_hist[e_tx + 5] !== 4'd6 || st_hist[e_tx + 6] !== 4'd7) begin errors++; $display("[TB] FAIL stray_wait_tx: got %0d,%0d want 6,7", st_hist[e_tx + 5], st_hist[e_tx + 6]); end
  endtask

  initial begin
    reset = 1'b0;
    ligar = 1'b0;
    test_reset();
    test_first_measure();
    test_sweep();
    test_timeout();
    test_boundary();
    test_ligar_drop();
    test_reset_mid();
    test_ignored();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sonar_sequenciador.md
SONAR_SEQUENCIADOR -- requirements
Module: sonar_sequenciador

Interface
REQ-001 Parameter T_POSICAO, default 25_000_000, servo settle time in clock cycles (0.5 s at 50 MHz).
REQ-002 Parameter T_TIMEOUT, default 3_000_000, maximum wait for a measurement in clock cycles (60 ms).
REQ-003 Port clock, input, 1, system clock (50 MHz); all state changes on rising edge.
REQ-004 Port reset, input, 1, asynchronous active-low reset.
REQ-005 Port ligar, input, 1, level; sweep enabled while high.
REQ-006 Port pronto_medida, input, 1, one-cycle pulse from the sensor interface when a distance is ready.
REQ-007 Port fim_transmissao, input, 1, one-cycle pulse from the serial transmitter at end of frame.
REQ-008 Port medir, output, 1, one-cycle pulse that starts a sensor measurement.
REQ-009 Port partida_tx, output, 1, one-cycle pulse that starts serial transmission of the measurement.
REQ-010 Port posicao, output, 3, current servo position index 0..7.
REQ-011 Port fim_posicao, output, 1, one-cycle pulse when the sweep reverses direction.
REQ-012 Port timeout, output, 1, one-cycle pulse when a measurement is abandoned.
REQ-013 Port db_estado, output, 4, current state encoding for the hex display.

Function
REQ-014 Moore FSM, encodings: INICIAL=0, PREPARA=1, ESPERA_POSICAO=2, MEDE=3, AGUARDA_MEDIDA=4, TRANSMITE=5, AGUARDA_TX=6, PROXIMA=7.
REQ-015 INICIAL: all pulse outputs low; move to PREPARA on the first edge with ligar=1; otherwise hold.
REQ-016 PREPARA: single cycle; posicao<=0, direction<=up, timer<=0; go to ESPERA_POSICAO.
REQ-017 ESPERA_POSICAO: timer increments each cycle; go to MEDE on the edge where timer==T_POSICAO-1; clear timer on exit.
REQ-018 MEDE: medir=1 for exactly this cycle; go to AGUARDA_MEDIDA.
REQ-019 AGUARDA_MEDIDA: pronto_medida=1 -> TRANSMITE; else timer==T_TIMEOUT-1 -> PROXIMA with timeout=1 for that one cycle; pronto_medida wins if both occur in the same cycle.
REQ-020 TRANSMITE: partida_tx=1 for exactly this cycle; go to AGUARDA_TX.
REQ-021 AGUARDA_TX: wait without limit for fim_transmissao=1, then go to PROXIMA.
REQ-022 PROXIMA: single cycle; ping-pong advance: up 0->7, down 7->0; at 7 going up, direction<=down and posicao<=6; at 0 going down, direction<=up and posicao<=1; fim_posicao=1 in this cycle only on reversal.
REQ-023 PROXIMA exit: ligar=1 -> ESPERA_POSICAO; ligar=0 -> INICIAL with posicao held.
REQ-024 ligar falling mid-cycle does not abort; the measurement/transmission in progress completes, and the block stops at PROXIMA.
REQ-025 pronto_medida and fim_transmissao are ignored in every state except their respective wait states.
REQ-026 Timer is 32 bits unsigned; T_POSICAO and T_TIMEOUT are 1..2^32-1.
REQ-027 db_estado = state encoding zero-extended to 4 bits.

Reset
REQ-028 reset=0 forces asynchronously: state=INICIAL, posicao=0, direction=up, timer=0; medir, partida_tx, fim_posicao, timeout low; db_estado=0.
REQ-029 Reset asserted in any state, including mid-wait, aborts with no further pulses; after release the block waits for ligar in INICIAL.

Configuration
REQ-030 Macro SONAR_SEQUENCIADOR_TIMEOUT_EN defined: AGUARDA_MEDIDA timeout per REQ-019 is active.
REQ-031 Macro not defined: AGUARDA_MEDIDA waits indefinitely for pronto_medida; timeout is tied low; T_POSICAO remains in effect.

Verification (T_POSICAO=10, T_TIMEOUT=20, macro defined unless noted)
REQ-032 Reset low, then release, ligar=0 for 100 cycles -> state 0, posicao=0, no pulses.
REQ-033 ligar=1; pronto_medida 5 cycles after medir; fim_transmissao 8 cycles after partida_tx -> first medir 12 cycles after ligar sampled (PREPARA + 10); partida_tx the cycle after pronto; posicao 0->1 in PROXIMA.
REQ-034 ligar held, all measurements answered -> posicao sequence 0,1,...,7,6,...,0,1; fim_posicao pulses exactly at the 7->6 and 0->1 steps.
REQ-035 pronto_medida never asserted -> timeout pulse 20 cycles after entering AGUARDA_MEDIDA; no partida_tx; posicao advances; with macro undefined, the FSM remains in state 4 for 1000 cycles.
REQ-036 pronto_medida and timer==19 in the same cycle -> partida_tx follows, no timeout pulse.
REQ-037 ligar dropped during AGUARDA_TX -> transmission completes, PROXIMA, then INICIAL; reset low during ESPERA_POSICAO -> immediate state 0, posicao=0.
